// File: rtl/mc_main_ctrl_hs.sv
// Main control FSM for the multicycle RV32 core with memory handshake, timeout trap and retire pulse.
// Define MULDIV_EN to enable the multi-cycle M-extension path (EXECM/MDWB states).
module mc_main_ctrl_hs #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       funct7_0,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       PCUpdate,
    output logic       Branch,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       md_start,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_JALRADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECR, S_EXECI, S_EXECM, S_LUI, S_AUIPC, S_JAL, S_BRANCH, S_ALUWB,
        S_MDWB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit             TMO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic             mem_wait;

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        mem_wait     = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE; else mem_wait = 1'b1;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_JALR:           state_d = S_JALRADR;
                    OP_RTYPE: begin
`ifdef MULDIV_EN
                        state_d = funct7_0 ? S_EXECM : S_EXECR;
`else
                        if (funct7_0) begin
                            state_d      = S_TRAP;
                            trap_cause_d = 2'b01;
                        end else begin
                            state_d = S_EXECR;
                        end
`endif
                    end
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_JALRADR:  state_d = S_JAL;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB; else mem_wait = 1'b1;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH; else mem_wait = 1'b1;
            S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
`ifdef MULDIV_EN
            S_EXECM:    if (md_done) state_d = S_MDWB;
            S_MDWB:     state_d = S_FETCH;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase

        // A ready cycle never reaches this point, so ready at the limit counts as success.
        tmo_d = '0;
        if (mem_wait) begin
            if (TMO_EN && (tmo_q == TMO_MAX)) begin
                state_d      = S_TRAP;
                trap_cause_d = 2'b10;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            tmo_q        <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            trap_cause_q <= trap_cause_d;
        end
    end

`ifdef MULDIV_EN
    logic md_busy_q, md_busy_d;

    // Busy marks every EXECM cycle after the first, so md_start fires once per launch.
    always_comb md_busy_d = (state_q == S_EXECM) && !md_done;

    always_ff @(posedge clk) begin
        if (reset) md_busy_q <= 1'b0;
        else       md_busy_q <= md_busy_d;
    end

    assign md_start = (state_q == S_EXECM) && !md_busy_q;
`else
    logic unused_md_done;
    assign unused_md_done = md_done;
    assign md_start       = 1'b0;
`endif

    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = 3'b000;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_BRANCH:        ImmSrc = 3'b010;
                    OP_JAL:           ImmSrc = 3'b011;
                    OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
                    default:          ImmSrc = 3'b000;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                ImmSrc   = 3'b011;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                ImmSrc  = 3'b010;
                retire  = 1'b1;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
`ifdef MULDIV_EN
            S_EXECM: begin
                ALUSrcA = 2'b10;
            end
            S_MDWB: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mc_main_ctrl_hs.sv
// Directed vector bench for mc_main_ctrl_hs (MEM_TIMEOUT=4); honours MULDIV_EN like the design.
module tb_mc_main_ctrl_hs;

    logic       clk = 1'b0;
    logic       reset, funct7_0, mem_ready, md_done;
    logic [6:0] op;
    logic       mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       md_start, retire, trap;
    logic [1:0] trap_cause;

    mc_main_ctrl_hs #(.MEM_TIMEOUT(4), .TMO_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct7_0(funct7_0),
        .mem_ready(mem_ready), .md_done(md_done),
        .mem_req(mem_req), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .PCUpdate(PCUpdate), .Branch(Branch), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .md_start(md_start), .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // {mem_req,MemWrite,RegWrite,IRWrite,AdrSrc,PCUpdate,Branch,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,md_start,retire,trap,trap_cause}
    wire [22:0] act = {mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, md_start, retire, trap, trap_cause};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        f7;
        logic        rdy;
        logic        mdd;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [6:0] ADD = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011, JALR = 7'b1100111,
                           BEQ = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           ADDI = 7'b0010011, JAL = 7'b1101111, BAD = 7'b1111111;

    function automatic logic [22:0] mk(input logic mr, mw, rw, irw, adr, pcu, br,
                                       input logic [1:0] rs, sa, sb, aop, input logic [2:0] imm,
                                       input logic mds, ret, trp, input logic [1:0] tc);
        return {mr, mw, rw, irw, adr, pcu, br, rs, sa, sb, aop, imm, mds, ret, trp, tc};
    endfunction

    function automatic logic [22:0] e_dec(input logic [2:0] imm);
        return mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0,0,0, 2'b00);
    endfunction
    function automatic logic [22:0] e_ma(input logic [2:0] imm);
        return mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0,0,0, 2'b00);
    endfunction
    function automatic logic [22:0] e_mw(input logic ret);
        return mk(1,1,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,ret,0, 2'b00);
    endfunction
    function automatic logic [22:0] e_trap(input logic [1:0] tc);
        return mk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0,1, tc);
    endfunction
    function automatic logic [22:0] e_xm(input logic first);
        return mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, first,0,0, 2'b00);
    endfunction

    logic [22:0] E_FW, E_FR, E_MR, E_MWB, E_XR, E_XI, E_LUI, E_AUI, E_JAL, E_BR, E_AWB, E_MDWB;

    task automatic add(input logic rst, input logic [6:0] o, input logic f7, input logic rdy,
                       input logic mdd, input logic [22:0] exp);
        vec_t v;
        v.rst = rst; v.op = o; v.f7 = f7; v.rdy = rdy; v.mdd = mdd; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    initial begin
        int n;
        E_FW  = mk(1,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0,0, 2'b00);
        E_FR  = mk(1,0,0,1,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0,0, 2'b00);
        E_MR  = mk(1,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0,0, 2'b00);
        E_MWB = mk(0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0,1,0, 2'b00);
        E_XR  = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0,0,0, 2'b00);
        E_XI  = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 0,0,0, 2'b00);
        E_LUI = mk(0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00, 3'b100, 0,0,0, 2'b00);
        E_AUI = mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 0,0,0, 2'b00);
        E_JAL = mk(0,0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0,0,0, 2'b00);
        E_BR  = mk(0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0,1,0, 2'b00);
        E_AWB = mk(0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,1,0, 2'b00);
        E_MDWB= mk(0,0,1,0,0,0,0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0,1,0, 2'b00);

        // reset state, then ADD
        add(0, ADD, 0, 0, 0, E_FW);
        add(0, ADD, 0, 1, 0, E_FR); add(0, ADD, 0, 1, 0, e_dec(3'b000));
        add(0, ADD, 0, 1, 0, E_XR); add(0, ADD, 0, 1, 0, E_AWB);
        // LW with fetch and read waits
        for (int i = 0; i < 3; i++) add(0, LW, 0, 0, 0, E_FW);
        add(0, LW, 0, 1, 0, E_FR); add(0, LW, 0, 0, 0, e_dec(3'b000)); add(0, LW, 0, 0, 0, e_ma(3'b000));
        add(0, LW, 0, 0, 0, E_MR); add(0, LW, 0, 0, 0, E_MR); add(0, LW, 0, 1, 0, E_MR);
        add(0, LW, 0, 0, 0, E_MWB);
        // JALR
        add(0, JALR, 0, 1, 0, E_FR); add(0, JALR, 0, 1, 0, e_dec(3'b000));
        add(0, JALR, 0, 1, 0, e_ma(3'b000)); add(0, JALR, 0, 1, 0, E_JAL); add(0, JALR, 0, 1, 0, E_AWB);
        // BEQ, LUI, AUIPC, ADDI, JAL
        add(0, BEQ, 0, 1, 0, E_FR); add(0, BEQ, 0, 1, 0, e_dec(3'b010)); add(0, BEQ, 0, 1, 0, E_BR);
        add(0, LUI, 0, 1, 0, E_FR); add(0, LUI, 0, 1, 0, e_dec(3'b100));
        add(0, LUI, 0, 1, 0, E_LUI); add(0, LUI, 0, 1, 0, E_AWB);
        add(0, AUIPC, 0, 1, 0, E_FR); add(0, AUIPC, 0, 1, 0, e_dec(3'b100));
        add(0, AUIPC, 0, 1, 0, E_AUI); add(0, AUIPC, 0, 1, 0, E_AWB);
        add(0, ADDI, 0, 1, 0, E_FR); add(0, ADDI, 0, 1, 0, e_dec(3'b000));
        add(0, ADDI, 0, 1, 0, E_XI); add(0, ADDI, 0, 1, 0, E_AWB);
        add(0, JAL, 0, 1, 0, E_FR); add(0, JAL, 0, 1, 0, e_dec(3'b011));
        add(0, JAL, 0, 1, 0, E_JAL); add(0, JAL, 0, 1, 0, E_AWB);
        // SW: ready arrives exactly when the wait counter reaches the limit
        add(0, SW, 0, 1, 0, E_FR); add(0, SW, 0, 0, 0, e_dec(3'b000)); add(0, SW, 0, 0, 0, e_ma(3'b001));
        for (int i = 0; i < 4; i++) add(0, SW, 0, 0, 0, e_mw(1'b0));
        add(0, SW, 0, 1, 0, e_mw(1'b1));
        // M-extension instruction
        add(0, ADD, 1, 1, 0, E_FR); add(0, ADD, 1, 1, 0, e_dec(3'b000));
`ifdef MULDIV_EN
        add(0, ADD, 1, 1, 0, e_xm(1'b1));
        for (int i = 0; i < 4; i++) add(0, ADD, 1, 1, 0, e_xm(1'b0));
        add(0, ADD, 1, 1, 1, e_xm(1'b0));
        add(0, ADD, 1, 1, 0, E_MDWB);
        add(0, ADD, 1, 1, 0, E_FR); add(0, ADD, 1, 1, 0, e_dec(3'b000));
        add(0, ADD, 1, 1, 1, e_xm(1'b1)); add(0, ADD, 1, 1, 0, E_MDWB);
`else
        add(0, ADD, 1, 1, 0, e_trap(2'b01)); add(0, ADD, 1, 1, 1, e_trap(2'b01));
        add(1, ADD, 1, 1, 0, e_trap(2'b01));
`endif
        add(0, ADD, 0, 0, 0, E_FW);
        // illegal opcode, reset recovery
        add(0, BAD, 0, 1, 0, E_FR); add(0, BAD, 0, 1, 0, e_dec(3'b000));
        add(0, BAD, 0, 1, 0, e_trap(2'b01)); add(0, BAD, 0, 1, 0, e_trap(2'b01));
        add(1, BAD, 0, 1, 0, e_trap(2'b01)); add(0, BAD, 0, 0, 0, E_FW);
        // SW timeout: five waiting cycles then a sticky trap
        add(0, SW, 0, 1, 0, E_FR); add(0, SW, 0, 0, 0, e_dec(3'b000)); add(0, SW, 0, 0, 0, e_ma(3'b001));
        for (int i = 0; i < 5; i++) add(0, SW, 0, 0, 0, e_mw(1'b0));
        for (int i = 0; i < 3; i++) add(0, SW, 0, 1, 0, e_trap(2'b10));
        add(1, SW, 0, 1, 0, e_trap(2'b10)); add(0, SW, 0, 0, 0, E_FW);
        // reset in the middle of a read wait
        add(0, LW, 0, 1, 0, E_FR); add(0, LW, 0, 0, 0, e_dec(3'b000)); add(0, LW, 0, 0, 0, e_ma(3'b000));
        add(0, LW, 0, 0, 0, E_MR); add(1, LW, 0, 0, 0, E_MR); add(0, LW, 0, 0, 0, E_FW);

        reset = 1'b1; op = ADD; funct7_0 = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct7_0 = vecs[i].f7;
            mem_ready = vecs[i].rdy; md_done = vecs[i].mdd;
            #1;
            chk($sformatf("vec%0d", i), {9'd0, act}, {9'd0, vecs[i].exp});
        end

        // Timeout counted with a bounded wait: the design is in FETCH with mem_ready low here.
        @(negedge clk); op = SW; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        n = 0;
        while (n < 50) begin
            @(negedge clk); #1;
            if (trap) break;
            n++;
        end
        chk("tmo_wait_cycles", n, 5);
        chk("tmo_cause", {30'd0, trap_cause}, {30'd0, 2'b10});
        chk("tmo_mem_req", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
